// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES output serializer slice.
//   AES_BLOCK_W  : width of one AES state block in bits
//   AES_BYTE_W   : width of one serial output byte
//   AES_NBYTES   : bytes per AES-128 block
//   ser_state_t  : serializer FSM state (IDLE / SHIFT)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage : aes_pkg

// File: rtl/aes_ser_skid.sv
// -----------------------------------------------------------------------------
// aes_ser_skid
// One-entry holding register for a block accepted while the serializer is
// still shifting out the previous one. Only instantiated when the
// AES_SER_SKID_EN macro is defined.
// Ports:
//   Clk     : clock, rising edge
//   Rst     : synchronous active-high reset, empties the buffer
//   i_push  : store i_data (only asserted while empty)
//   i_data  : block to store
//   i_pop   : release the stored block (consumer copies o_data this edge)
//   o_full  : buffer holds a block
//   o_data  : stored block
// -----------------------------------------------------------------------------
module aes_ser_skid
    import aes_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   i_push,
    input  logic [AES_BLOCK_W-1:0] i_data,
    input  logic                   i_pop,
    output logic                   o_full,
    output logic [AES_BLOCK_W-1:0] o_data
);

    logic                   r_full;
    logic [AES_BLOCK_W-1:0] r_data;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule : aes_ser_skid

// File: rtl/aes_out_serializer.sv
// -----------------------------------------------------------------------------
// aes_out_serializer
// Converts a 128-bit AES state block into a stream of bytes, most significant
// byte first, with valid/ready handshakes on both sides.
// Ports:
//   Clk       : clock, rising edge
//   Rst       : synchronous active-high reset
//   In_Block  : 128-bit cipher state from the AES core
//   In_Valid  : In_Block valid
//   In_Ready  : block can be accepted this cycle
//   Out_Byte  : current serial byte
//   Out_Valid : Out_Byte valid
//   Out_Ready : downstream accepts Out_Byte
//   Out_Last  : Out_Byte is the final byte of the block
// Build option:
//   AES_SER_SKID_EN : adds a one-entry skid buffer so a following block can be
//                     accepted during SHIFT and streamed without a bubble.
// -----------------------------------------------------------------------------
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_NBYTES
)
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [AES_BLOCK_W-1:0] In_Block,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    output logic [AES_BYTE_W-1:0]  Out_Byte,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic                   Out_Last
);

    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    ser_state_t             r_state;
    logic [AES_BLOCK_W-1:0] r_shift;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_in_acc;
    logic                   w_out_xfer;
    logic                   w_last_xfer;
    // A block ready to follow the current one on its last-byte transfer.
    logic                   w_pend_valid;
    logic [AES_BLOCK_W-1:0] w_pend_block;

    assign Out_Valid   = (r_state == SHIFT);
    assign Out_Byte    = r_shift[AES_BLOCK_W-1 -: AES_BYTE_W];
    assign Out_Last    = Out_Valid && (r_cnt == LAST_CNT);

    assign w_in_acc    = In_Valid && In_Ready;
    assign w_out_xfer  = Out_Valid && Out_Ready;
    assign w_last_xfer = w_out_xfer && (r_cnt == LAST_CNT);

`ifdef AES_SER_SKID_EN
    logic                   w_skid_full;
    logic [AES_BLOCK_W-1:0] w_skid_data;
    logic                   w_skid_push;
    logic                   w_skid_pop;

    // A block arriving on the same edge as the last-byte transfer (skid empty)
    // goes straight into the shift register, so only park it otherwise.
    assign w_skid_push = w_in_acc && (r_state == SHIFT) && !w_last_xfer;
    assign w_skid_pop  = w_last_xfer && w_skid_full;

    aes_ser_skid u_skid (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_push (w_skid_push),
        .i_data (In_Block),
        .i_pop  (w_skid_pop),
        .o_full (w_skid_full),
        .o_data (w_skid_data)
    );

    assign In_Ready     = !w_skid_full;
    // Skid full implies no accept this cycle, so the two sources never collide.
    assign w_pend_valid = w_skid_full || (w_in_acc && (r_state == SHIFT));
    assign w_pend_block = w_skid_full ? w_skid_data : In_Block;
`else
    assign In_Ready     = (r_state == IDLE);
    assign w_pend_valid = 1'b0;
    assign w_pend_block = '0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_acc) begin
                        r_state <= SHIFT;
                        r_shift <= In_Block;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (w_last_xfer) begin
                        r_cnt <= '0;
                        if (w_pend_valid) begin
                            r_shift <= w_pend_block;
                        end else begin
                            r_state <= IDLE;
                            // Shifting the final byte out leaves zeros, so
                            // Out_Byte reads 00 while idle.
                            r_shift <= r_shift << AES_BYTE_W;
                        end
                    end else if (w_out_xfer) begin
                        r_shift <= r_shift << AES_BYTE_W;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : aes_out_serializer

// File: tb/tb_aes_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_out_serializer
// Directed bench for aes_out_serializer. Inputs change and outputs are checked
// on the falling edge; the DUT acts on the rising edge.
// Skid-buffer scenarios are compiled in when AES_SER_SKID_EN is defined.
// -----------------------------------------------------------------------------
module tb_aes_out_serializer;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [127:0] In_Block;
    logic         In_Valid;
    logic         In_Ready;
    logic [7:0]   Out_Byte;
    logic         Out_Valid;
    logic         Out_Ready;
    logic         Out_Last;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    aes_out_serializer #(.NBYTES(16)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Block  (In_Block),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Out_Byte  (Out_Byte),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Last  (Out_Last)
    );

    localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B3 = 128'h0f0e0d0c0b0a09080706050403020100;

    logic [7:0] b2_bytes [16] = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
                                  8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one block for a single accepting edge (caller ensures In_Ready).
    task automatic load_block(input logic [127:0] blk);
        In_Block = blk;
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
    endtask

    // B1 byte k is k*0x11; B3 byte k is 15-k.
    function automatic logic [7:0] b1_byte(input int k);
        return 8'(k * 17);
    endfunction

    function automatic logic [7:0] b3_byte(input int k);
        return 8'(15 - k);
    endfunction

    initial begin
        int k;
        Rst       = 1'b1;
        In_Block  = '0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        @(negedge Clk);
        tick();
        Rst = 1'b0;

        // ---------------- reset state ----------------
        chk("rst_out_valid", {7'd0, Out_Valid}, 8'd0);
        chk("rst_out_last",  {7'd0, Out_Last},  8'd0);
        chk("rst_out_byte",  Out_Byte,          8'h00);
        chk("rst_in_ready",  {7'd0, In_Ready},  8'd1);
        $display("[TB] reset state checked");

        // ---------------- basic streaming ----------------
        Out_Ready = 1'b1;
        load_block(B1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("basic_valid_%0d", i), {7'd0, Out_Valid}, 8'd1);
            chk($sformatf("basic_byte_%0d", i),  Out_Byte, b1_byte(i));
            chk($sformatf("basic_last_%0d", i),  {7'd0, Out_Last}, {7'd0, (i == 15)});
`ifndef AES_SER_SKID_EN
            chk($sformatf("basic_inrdy_%0d", i), {7'd0, In_Ready}, 8'd0);
`endif
            $display("[TB] basic byte %0d = %h last=%0b", i, Out_Byte, Out_Last);
            tick();
        end
        chk("basic_end_valid", {7'd0, Out_Valid}, 8'd0);
        chk("basic_end_ready", {7'd0, In_Ready},  8'd1);
        chk("basic_end_last",  {7'd0, Out_Last},  8'd0);

        // ---------------- backpressure, Out_Ready toggling ----------------
        load_block(B1);
        k = 0;
        for (int c = 0; c < 40 && k < 16; c++) begin
            chk($sformatf("bp_valid_c%0d", c), {7'd0, Out_Valid}, 8'd1);
            chk($sformatf("bp_byte_c%0d", c),  Out_Byte, b1_byte(k));
            chk($sformatf("bp_last_c%0d", c),  {7'd0, Out_Last}, {7'd0, (k == 15)});
            Out_Ready = ((c % 2) == 0);
            $display("[TB] bp cycle %0d byte %h ready=%0b", c, Out_Byte, Out_Ready);
            tick();
            if (Out_Ready) k++;
        end
        chk("bp_all_bytes", 8'(k), 8'd16);
        Out_Ready = 1'b1;
        chk("bp_end_valid", {7'd0, Out_Valid}, 8'd0);

        // ---------------- long stall then drain ----------------
        Out_Ready = 1'b0;
        load_block(B3);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall_byte_%0d", i), Out_Byte, 8'h0f);
            chk($sformatf("stall_valid_%0d", i), {7'd0, Out_Valid}, 8'd1);
            tick();
        end
        Out_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("stall_drain_%0d", i), Out_Byte, b3_byte(i));
            tick();
        end
        chk("stall_end_valid", {7'd0, Out_Valid}, 8'd0);
        $display("[TB] stall/drain checked");

`ifndef AES_SER_SKID_EN
        // ---------------- ignored input during SHIFT ----------------
        load_block(B1);
        In_Block = '1;
        In_Valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) In_Valid = 1'b0;
            chk($sformatf("ign_byte_%0d", i), Out_Byte, b1_byte(i));
            chk($sformatf("ign_inrdy_%0d", i), {7'd0, In_Ready}, 8'd0);
            $display("[TB] ignore byte %0d = %h", i, Out_Byte);
            tick();
        end
        chk("ign_end_valid", {7'd0, Out_Valid}, 8'd0);
        chk("ign_end_byte",  Out_Byte, 8'h00);
        tick();
        chk("ign_not_taken", {7'd0, Out_Valid}, 8'd0);
`endif

        // ---------------- reset mid-block ----------------
        load_block(B1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("mid_byte_%0d", i), Out_Byte, b1_byte(i));
            tick();
        end
        // Reset coincides with an output transfer (Out_Ready=1).
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("mid_rst_valid", {7'd0, Out_Valid}, 8'd0);
        chk("mid_rst_ready", {7'd0, In_Ready},  8'd1);
        chk("mid_rst_byte",  Out_Byte,          8'h00);
        chk("mid_rst_last",  {7'd0, Out_Last},  8'd0);
        tick();
        chk("mid_rst_stays_idle", {7'd0, Out_Valid}, 8'd0);
        load_block(B3);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("post_rst_byte_%0d", i), Out_Byte, b3_byte(i));
            chk($sformatf("post_rst_last_%0d", i), {7'd0, Out_Last}, {7'd0, (i == 15)});
            $display("[TB] post-reset byte %0d = %h", i, Out_Byte);
            tick();
        end
        chk("post_rst_end_valid", {7'd0, Out_Valid}, 8'd0);

`ifdef AES_SER_SKID_EN
        // ---------------- skid: three back-to-back blocks ----------------
        load_block(B1);
        for (int i = 0; i < 48; i++) begin
            logic [7:0] exp_b;
            logic       exp_rdy;
            if (i < 16)      exp_b = b1_byte(i);
            else if (i < 32) exp_b = b2_bytes[i - 16];
            else             exp_b = b3_byte(i - 32);
            exp_rdy = (i == 0) || (i == 16) || (i >= 32);
            chk($sformatf("skid_valid_%0d", i), {7'd0, Out_Valid}, 8'd1);
            chk($sformatf("skid_byte_%0d", i),  Out_Byte, exp_b);
            chk($sformatf("skid_last_%0d", i),  {7'd0, Out_Last}, {7'd0, ((i % 16) == 15)});
            chk($sformatf("skid_inrdy_%0d", i), {7'd0, In_Ready}, {7'd0, exp_rdy});
            In_Valid = (i <= 16);
            In_Block = (i == 0) ? B2 : B3;
            $display("[TB] skid byte %0d = %h rdy=%0b", i, Out_Byte, In_Ready);
            tick();
        end
        In_Valid = 1'b0;
        chk("skid_end_valid", {7'd0, Out_Valid}, 8'd0);
        chk("skid_end_ready", {7'd0, In_Ready},  8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_aes_out_serializer
